// File: rtl/pattern_presenter_pkg.sv
// Shared definitions for the memory-game pattern presenter and related game blocks.
// Holds the FSM state encoding, the LFSR tap mask, the default seed, the symbol width
// and the Galois LFSR step function.
package pattern_presenter_pkg;

    localparam int unsigned SYM_W         = 4;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StGen  = 3'd1,
        StShow = 3'd2,
        StGap  = 3'd3,
        StDone = 3'd4
    } state_e;

    // Galois right-shift step: the shifted-out bit folds the tap mask back in.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

endpackage

// File: rtl/pattern_presenter_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset (state returns to RESET_SEED)
//   load_i     load load_val_i on the next clock (wins over step_i)
//   load_val_i value to load
//   step_i     advance one Galois step on the next clock
//   state_o    current LFSR state
module pattern_presenter_lfsr16
    import pattern_presenter_pkg::*;
#(
    parameter logic [15:0] RESET_SEED = LFSR_DEF_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RESET_SEED;
        end else if (load_i) begin
            state_q <= load_val_i;
        end else if (step_i) begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/pattern_presenter.sv
// Transmit side of the memory-game protocol. A start pulse latches a clamped length,
// seeds the LFSR, generates one symbol per clock into a small buffer, then plays the
// symbols out one-hot on the LEDs, each lit for ON_TICKS ticks and followed by
// GAP_TICKS blank ticks. The buffer stays readable through rd_idx/rd_sym after done.
//
// Optional feature macro: PRESENTER_REPLAY_EN adds a 'replay' input that replays the
// stored sequence from IDLE without regenerating it.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start              single-cycle pulse, accepted only in IDLE
//   seed               LFSR seed (0 selects DEF_SEED), sampled on accepted start
//   level              requested length, clamped to 1..SEQ_MAX
//   tick               time-base enable, counted only while showing or in the gap
//   replay             (PRESENTER_REPLAY_EN only) replay stored sequence from IDLE
//   led                one-hot of the lit symbol, zero when blank
//   sym_out/sym_valid  lit symbol and its qualifier
//   busy               high from accepted start until done
//   done               one-cycle pulse at end of playback
//   seq_len            latched effective length
//   rd_idx/rd_sym      combinational read-back, zero for rd_idx >= seq_len
module pattern_presenter
    import pattern_presenter_pkg::*;
#(
    parameter int unsigned SEQ_MAX   = 8,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned GAP_TICKS = 1,
    parameter logic [15:0] DEF_SEED  = LFSR_DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [3:0]       level,
    input  logic             tick,
`ifdef PRESENTER_REPLAY_EN
    input  logic             replay,
`endif
    output logic [15:0]      led,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    output logic             busy,
    output logic             done,
    output logic [3:0]       seq_len,
    input  logic [2:0]       rd_idx,
    output logic [SYM_W-1:0] rd_sym
);

    localparam logic [3:0] SeqMaxL = 4'(SEQ_MAX);
    localparam logic [7:0] OnLast  = 8'(ON_TICKS - 1);
    localparam logic [7:0] GapLast = 8'(GAP_TICKS - 1);

    state_e           state_q;
    logic [2:0]       idx_q;
    logic [7:0]       cnt_q;
    logic [3:0]       seq_len_q;
    logic [SYM_W-1:0] mem_q [SEQ_MAX];
    logic [15:0]      led_q;
    logic [SYM_W-1:0] sym_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0]       len_clamped;
    logic [15:0]      seed_eff;
    logic             accept;
    logic             replay_go;
    logic [15:0]      lfsr_state;
    logic [15:0]      lfsr_next;
    logic [SYM_W-1:0] gen_sym;
    logic [SYM_W-1:0] first_sym;
    logic [SYM_W-1:0] next_sym;
    logic             at_last;
    logic             on_done;
    logic             gap_done;
    logic             unused_lfsr_hi;

    always_comb begin
        len_clamped = level;
        if (level == 4'd0) begin
            len_clamped = 4'd1;
        end else if (level > SeqMaxL) begin
            len_clamped = SeqMaxL;
        end
    end

    assign seed_eff = (seed == 16'h0000) ? DEF_SEED : seed;
    assign accept   = (state_q == StIdle) && start;

`ifdef PRESENTER_REPLAY_EN
    // start has priority; an empty buffer has nothing to replay.
    assign replay_go = (state_q == StIdle) && !start && replay && (seq_len_q != 4'd0);
`else
    assign replay_go = 1'b0;
`endif

    pattern_presenter_lfsr16 #(
        .RESET_SEED(DEF_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .load_val_i(seed_eff),
        .step_i    (state_q == StGen),
        .state_o   (lfsr_state)
    );

    // The stored symbol is taken from the stepped value, matching what the LFSR
    // register holds after this clock.
    assign lfsr_next      = lfsr_step(lfsr_state);
    assign gen_sym        = lfsr_next[SYM_W-1:0];
    assign unused_lfsr_hi = ^lfsr_next[15:SYM_W];

    // For a length-1 sequence buffer slot 0 is written on the same edge we enter SHOW.
    assign first_sym = (idx_q == 3'd0) ? gen_sym : mem_q[0];
    assign next_sym  = mem_q[idx_q + 3'd1];
    assign at_last   = ({1'b0, idx_q} == (seq_len_q - 4'd1));
    assign on_done   = (ON_TICKS == 0) || (tick && (cnt_q == OnLast));
    assign gap_done  = (GAP_TICKS == 0) || (tick && (cnt_q == GapLast));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= 3'd0;
            cnt_q     <= 8'd0;
            seq_len_q <= 4'd0;
            led_q     <= 16'h0000;
            sym_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < int'(SEQ_MAX); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        seq_len_q <= len_clamped;
                        idx_q     <= 3'd0;
                        busy_q    <= 1'b1;
                        state_q   <= StGen;
                    end else if (replay_go) begin
                        idx_q   <= 3'd0;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        led_q   <= 16'h0001 << mem_q[0];
                        sym_q   <= mem_q[0];
                        valid_q <= 1'b1;
                        state_q <= StShow;
                    end
                end
                StGen: begin
                    mem_q[idx_q] <= gen_sym;
                    if (at_last) begin
                        idx_q   <= 3'd0;
                        cnt_q   <= 8'd0;
                        led_q   <= 16'h0001 << first_sym;
                        sym_q   <= first_sym;
                        valid_q <= 1'b1;
                        state_q <= StShow;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                StShow: begin
                    if (on_done) begin
                        cnt_q   <= 8'd0;
                        led_q   <= 16'h0000;
                        sym_q   <= '0;
                        valid_q <= 1'b0;
                        state_q <= StGap;
                    end else if (tick) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StGap: begin
                    if (gap_done) begin
                        cnt_q <= 8'd0;
                        if (at_last) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            led_q   <= 16'h0001 << next_sym;
                            sym_q   <= next_sym;
                            valid_q <= 1'b1;
                            state_q <= StShow;
                        end
                    end else if (tick) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign led       = led_q;
    assign sym_out   = sym_q;
    assign sym_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign seq_len   = seq_len_q;
    assign rd_sym    = ({1'b0, rd_idx} < seq_len_q) ? mem_q[rd_idx] : '0;

endmodule

// File: tb/tb_pattern_presenter.sv
// Self-checking bench for pattern_presenter: table of seed/level vectors with expected
// symbol lists, played with tick held high and checked cycle by cycle, plus hand-written
// sequences for sparse ticks with a start while busy, reset mid-playback and replay.
module tb_pattern_presenter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic [3:0]  level;
    logic        tick;
    logic [2:0]  rd_idx;
    logic [15:0] led;
    logic [3:0]  sym_out;
    logic        sym_valid;
    logic        busy;
    logic        done;
    logic [3:0]  seq_len;
    logic [3:0]  rd_sym;
`ifdef PRESENTER_REPLAY_EN
    logic        replay;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_presenter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .seed     (seed),
        .level    (level),
        .tick     (tick),
`ifdef PRESENTER_REPLAY_EN
        .replay   (replay),
`endif
        .led      (led),
        .sym_out  (sym_out),
        .sym_valid(sym_valid),
        .busy     (busy),
        .done     (done),
        .seq_len  (seq_len),
        .rd_idx   (rd_idx),
        .rd_sym   (rd_sym)
    );

    // syms holds symbol k in nibble k (lowest nibble is the first symbol shown).
    typedef struct packed {
        logic [15:0] seed;
        logic [3:0]  level;
        logic [3:0]  len;
        logic [31:0] syms;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic [15:0] e_led, input logic [3:0] e_sym,
                              input logic e_valid, input logic e_busy, input logic e_done);
        chk($sformatf("%s led", tag), 32'(led), 32'(e_led));
        chk($sformatf("%s valid", tag), 32'(sym_valid), 32'(e_valid));
        chk($sformatf("%s busy", tag), 32'(busy), 32'(e_busy));
        chk($sformatf("%s done", tag), 32'(done), 32'(e_done));
        if (e_valid) chk($sformatf("%s sym", tag), 32'(sym_out), 32'(e_sym));
        step();
    endtask

    // Playback with tick high every cycle: 2 lit cycles, 1 blank, then done, then idle.
    task automatic check_show(input vec_t t, input string tag);
        logic [3:0] s;
        for (int k = 0; k < int'(t.len); k++) begin
            s = t.syms[4*k +: 4];
            expect_cyc($sformatf("%s s%0d lit0", tag, k), 16'h0001 << s, s, 1'b1, 1'b1, 1'b0);
            expect_cyc($sformatf("%s s%0d lit1", tag, k), 16'h0001 << s, s, 1'b1, 1'b1, 1'b0);
            expect_cyc($sformatf("%s s%0d gap", tag, k), 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0);
        end
        expect_cyc($sformatf("%s done", tag), 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1);
        expect_cyc($sformatf("%s idle", tag), 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_readback(input vec_t t, input string tag);
        chk($sformatf("%s seq_len", tag), 32'(seq_len), 32'(t.len));
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            chk($sformatf("%s rd_sym[%0d]", tag, i), 32'(rd_sym),
                (i < int'(t.len)) ? 32'(t.syms[4*i +: 4]) : 32'h0);
        end
        rd_idx = 3'd0;
    endtask

    // Start with tick held high (start+tick in IDLE keeps the start, drops the tick).
    task automatic run_vec(input int v);
        vec_t t;
        t = vecs[v];
        seed  = t.seed;
        level = t.level;
        tick  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < int'(t.len); i++) begin
            expect_cyc($sformatf("v%0d gen%0d", v, i), 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0);
        end
        check_show(t, $sformatf("v%0d", v));
        check_readback(t, $sformatf("v%0d", v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   t3;
        int     lit_ticks [3];
        int     gap_ticks [3];
        logic [15:0] seen [3];
        int     sym_idx;
        int     done_cnt;
        logic   got_done;
        logic   poked;
        logic   found;
        logic [15:0] prev_led;

        vecs[0] = '{16'hACE1, 4'd3,  4'd3, 32'h0000_0C80};
        vecs[1] = '{16'h0000, 4'd3,  4'd3, 32'h0000_0C80};
        vecs[2] = '{16'hACE1, 4'd0,  4'd1, 32'h0000_0000};
        vecs[3] = '{16'hACE1, 4'd12, 4'd8, 32'h4937_EC80};
        vecs[4] = '{16'h000F, 4'd4,  4'd4, 32'h0000_0137};

        rst    = 1'b0;
        start  = 1'b0;
        seed   = 16'h0000;
        level  = 4'd0;
        tick   = 1'b0;
        rd_idx = 3'd0;
`ifdef PRESENTER_REPLAY_EN
        replay = 1'b0;
`endif
        step();
        step();
        chk("reset led", 32'(led), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset valid", 32'(sym_valid), 32'h0);
        chk("reset seq_len", 32'(seq_len), 32'h0);
        chk("reset rd_sym", 32'(rd_sym), 32'h0);
        rst = 1'b1;

        // Ticks in IDLE do nothing.
        tick = 1'b1;
        step();
        step();
        expect_cyc("idle ticks", 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 5; v++) begin
            run_vec(v);
        end

        // Sparse ticks (every third cycle) with a start pulse during the second symbol.
        t3        = vecs[0];
        seed      = 16'hACE1;
        level     = 4'd3;
        tick      = 1'b0;
        start     = 1'b1;
        step();
        start     = 1'b0;
        sym_idx   = -1;
        done_cnt  = 0;
        got_done  = 1'b0;
        poked     = 1'b0;
        prev_led  = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            lit_ticks[i] = 0;
            gap_ticks[i] = 0;
            seen[i]      = 16'h0000;
        end
        for (int c = 0; c < 300 && !got_done; c++) begin
            if (done) begin
                done_cnt++;
                got_done = 1'b1;
            end else begin
                if (led != 16'h0000 && prev_led == 16'h0000) begin
                    sym_idx++;
                    if (sym_idx < 3) seen[sym_idx] = led;
                end
                prev_led = led;
                tick     = (c % 3 == 2);
                start    = 1'b0;
                if (sym_idx == 1 && sym_valid && !poked) begin
                    start = 1'b1;
                    poked = 1'b1;
                end
                if (tick && sym_idx >= 0 && sym_idx < 3) begin
                    if (sym_valid) lit_ticks[sym_idx]++;
                    else if (busy) gap_ticks[sym_idx]++;
                end
                step();
            end
        end
        start = 1'b0;
        tick  = 1'b0;
        chk("sparse reached done", 32'(got_done), 32'h1);
        chk("sparse symbol count", 32'(sym_idx + 1), 32'd3);
        chk("sparse led0", 32'(seen[0]), 32'h0001);
        chk("sparse led1", 32'(seen[1]), 32'h0100);
        chk("sparse led2", 32'(seen[2]), 32'h1000);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sparse lit ticks s%0d", i), 32'(lit_ticks[i]), 32'd2);
            chk($sformatf("sparse gap ticks s%0d", i), 32'(gap_ticks[i]), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) done_cnt++;
        end
        chk("sparse done pulses", 32'(done_cnt), 32'd1);
        check_readback(t3, "sparse");

        // Reset asserted during the second symbol.
        seed  = 16'hACE1;
        level = 4'd3;
        tick  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (led == 16'h0100) found = 1'b1;
            else step();
        end
        chk("rst reached second symbol", 32'(found), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst async led", 32'(led), 32'h0);
        chk("rst async busy", 32'(busy), 32'h0);
        chk("rst async valid", 32'(sym_valid), 32'h0);
        step();
        rst      = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) done_cnt++;
        end
        chk("rst no done/busy after release", 32'(done_cnt), 32'd0);
        chk("rst seq_len", 32'(seq_len), 32'h0);
        rd_idx = 3'd0;
        #1;
        chk("rst rd_sym", 32'(rd_sym), 32'h0);

`ifdef PRESENTER_REPLAY_EN
        // Empty buffer: replay ignored.
        replay = 1'b1;
        step();
        replay = 1'b0;
        expect_cyc("replay empty", 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0);
        run_vec(0);
        tick   = 1'b1;
        replay = 1'b1;
        step();
        replay = 1'b0;
        check_show(vecs[0], "replay");
        check_readback(vecs[0], "replay");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_presenter.md
Name: pattern_presenter

Overview:
Transmit side of the memory-game protocol. On a shaped start pulse it generates a pseudo-random symbol sequence with an LFSR, stores it, and plays it out on the red LEDs one symbol at a time using a tick time base. The access controller is the receiving end: it compares player switch entries against the stored sequence through the read-back port.

Parameters:
SEQ_MAX, 8, maximum sequence length (buffer depth); must be a power of 2, max 8
ON_TICKS, 2, number of ticks each symbol is lit
GAP_TICKS, 1, number of blank ticks after each symbol
DEF_SEED, 16'hACE1, seed substituted when the supplied seed is zero

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  single-cycle shaped pulse; begins a generate+show cycle
seed  in  16  LFSR seed, sampled on an accepted start
level  in  4  requested sequence length
tick  in  1  single-cycle time-base enable (one-second timer output)
led  out  16  one-hot display of the current symbol (1 << sym); all zero when blank
sym_out  out  4  current symbol being shown
sym_valid  out  1  high while a symbol is lit
busy  out  1  high from an accepted start until done
done  out  1  single-cycle pulse when playback completes
seq_len  out  4  latched effective length of the current sequence
rd_idx  in  3  read-back index
rd_sym  out  4  stored symbol at rd_idx; combinational read

Behaviour:
- Reset (rst=0, asynchronous) clears all outputs, the buffer, the counters and seq_len, and sets state IDLE. The LFSR resets to DEF_SEED.
- States: IDLE, GEN, SHOW, GAP, DONE.
- IDLE: start=1 is accepted.
  - Latch len = clamp(level): 0 becomes 1; values above SEQ_MAX become SEQ_MAX.
  - Load the LFSR with seed, or with DEF_SEED if seed==0.
  - Set idx=0, busy=1 next cycle, go to GEN.
- GEN: one symbol per clock.
  - LFSR step is Galois: lsb=l[0]; l=l>>1; if lsb then l^=16'hB400.
  - buf[idx] = stepped l[3:0].
  - After len cycles: idx=0, tick counter=0, go to SHOW.
- SHOW: led=1<<buf[idx], sym_out=buf[idx], sym_valid=1. Count ticks; after ON_TICKS ticks go to GAP with the counter cleared.
- GAP: led=0, sym_valid=0. After GAP_TICKS ticks:
  - if idx==len-1, go to DONE;
  - else idx++ and go to SHOW.
  - GAP_TICKS=0 means GAP lasts exactly one clock.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- start while busy is ignored; it has no effect on the sequence, the timing or the LFSR.
- tick during IDLE, GEN or DONE is ignored. Ticks are counted only in SHOW and GAP.
- start and tick arriving in the same cycle in IDLE: start is accepted, tick is discarded.
- The buffer and seq_len persist after DONE until the next accepted start or reset, so the checker can read them.
- rd_idx >= seq_len returns 0.
- Generation latency: len+1 clocks from start to the first lit symbol. Total playback is len*(ON_TICKS+GAP_TICKS) ticks.
- Reset asserted mid-playback: led goes to 0 immediately (asynchronous), and no done pulse is produced.

Optional Feature:
PRESENTER_REPLAY_EN
- Defined: adds input port replay (1-bit pulse). replay in IDLE with seq_len!=0 goes directly to SHOW with idx=0, skipping GEN; the buffer and LFSR are unchanged. replay with seq_len==0 or while busy is ignored. If start and replay coincide, start wins.
- Undefined: the port is absent and only start initiates playback.

Decomposition:
- Shared package/header: state encodings (IDLE=0, GEN=1, SHOW=2, GAP=3, DONE=4), the 16'hB400 tap mask, DEF_SEED, and the symbol width of 4.
- One natural sub-module: lfsr16 (load, step enable, 16-bit state out), reusable by other game blocks.
- The buffer and FSM stay in pattern_presenter.

Test Plan:
- Seed 16'hACE1, level=3, start -> buf = {0x0, 0x8, 0xC}. led sequence 16'h0001, 16'h0100, 16'h1000, each lit 2 ticks with a 1-tick blank between. done pulses once; seq_len=3.
- level=0 and level=12 -> seq_len=1 and seq_len=8 respectively; exactly that many symbols are shown.
- seed=0 -> same sequence as seed 16'hACE1. start pulsed again mid-SHOW -> ignored; the sequence and timing are unchanged.
- rst low during the second SHOW -> led=0 and busy=0 the same cycle; no done pulse. After release, IDLE with seq_len=0 and rd_sym=0.
- After done, rd_idx 0..2 -> 0x0, 0x8, 0xC; rd_idx=5 -> 0. tick held high every cycle still gives exactly ON_TICKS cycles lit per symbol.
- With PRESENTER_REPLAY_EN defined, replay after done -> the identical led sequence replays with no GEN cycles (first symbol lit on the next clock), and done pulses again.
